// File: rtl/battle_turn_ctrl.sv
// Turn sequencer for a multi-player battle: gathers each combatant's attack choice from PS/2
// keys (or a default on timeout), rotates turns on hits, and tracks wins, level-ups and boss mode.
module battle_turn_ctrl #(
   parameter int unsigned NUM_PLAYERS = 2,
   parameter int unsigned WIN_W       = 8,
   parameter int unsigned LEVEL_WINS  = 4,
   parameter int unsigned BOSS_WINS   = 12,
   parameter int unsigned TIMEOUT_CYC = 50_000_000
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       key_valid,
   input  logic [7:0]                 key_code,
   input  logic                       battle_start,
   input  logic                       collision_detected,
   input  logic                       player_win,
   input  logic                       enemy_win,
   output logic [NUM_PLAYERS-1:0]     turn,
   output logic [2*NUM_PLAYERS-1:0]   choice,
   output logic [NUM_PLAYERS-1:0]     choice_valid,
   output logic                       attack_go,
   output logic [WIN_W-1:0]           win_count,
   output logic                       level_up,
   output logic                       boss
);

   localparam int unsigned CntW = $clog2(TIMEOUT_CYC);
   localparam int unsigned LvlW = $clog2(LEVEL_WINS + 1);
   localparam logic [CntW-1:0]  CntLast = CntW'(TIMEOUT_CYC - 1);
   localparam logic [LvlW-1:0]  LvlLast = LvlW'(LEVEL_WINS - 1);
   localparam logic [WIN_W-1:0] WinMax  = '1;

   typedef enum logic [1:0] {StIdle, StChoose, StAttack, StDone} state_e;

   state_e                     state_q, state_d;
   logic [NUM_PLAYERS-1:0]     turn_q, turn_d;
   logic [2*NUM_PLAYERS-1:0]   choice_q, choice_d;
   logic [NUM_PLAYERS-1:0]     cv_q, cv_d;
   logic                       go_q, go_d;
   logic [CntW-1:0]            cnt_q, cnt_d;
   logic [WIN_W-1:0]           win_q, win_d;
   logic [LvlW-1:0]            lvl_q, lvl_d;
   logic                       lu_q, lu_d;
   logic                       boss_q, boss_d;
   logic                       hit;
   logic [1:0]                 pick;
   logic [2:0]                 lk;

   // Returns {hit, attack code} for a key in player p's map.
   function automatic logic [2:0] key_lookup(input int unsigned p, input logic [7:0] code);
      logic [2:0] r;
      r = 3'b000;
      case (p)
         0: case (code)
               8'h1C: r = 3'b100;
               8'h1B: r = 3'b101;
               8'h23: r = 3'b110;
               8'h1D: r = 3'b111;
               default: r = 3'b000;
            endcase
         1: case (code)
               8'h3B: r = 3'b100;
               8'h42: r = 3'b101;
               8'h4B: r = 3'b110;
               8'h43: r = 3'b111;
               default: r = 3'b000;
            endcase
         2: case (code)
               8'h16: r = 3'b100;
               8'h1E: r = 3'b101;
               8'h26: r = 3'b110;
               8'h25: r = 3'b111;
               default: r = 3'b000;
            endcase
         3: case (code)
               8'h70: r = 3'b100;
               8'h69: r = 3'b101;
               8'h72: r = 3'b110;
               8'h7A: r = 3'b111;
               default: r = 3'b000;
            endcase
         default: r = 3'b000;
      endcase
      return r;
   endfunction

   always_comb begin
      state_d  = state_q;
      turn_d   = turn_q;
      choice_d = choice_q;
      cv_d     = cv_q;
      go_d     = 1'b0;
      cnt_d    = cnt_q;
      win_d    = win_q;
      lvl_d    = lvl_q;
      lu_d     = 1'b0;
      hit      = 1'b0;
      pick     = 2'b00;
      lk       = 3'b000;
      unique case (state_q)
         StIdle: begin
            if (battle_start) begin
               state_d  = StChoose;
               turn_d   = NUM_PLAYERS'(1);
               choice_d = '0;
               cv_d     = '0;
               cnt_d    = '0;
            end
         end
         StChoose, StAttack: begin
            if (player_win || enemy_win) begin
               state_d = StDone;
               turn_d  = '0;
               // Enemy win takes priority; a tie never credits the player.
               if (!enemy_win && win_q != WinMax) begin
                  win_d = win_q + 1'b1;
                  if (lvl_q == LvlLast) begin
                     lvl_d = '0;
                     lu_d  = 1'b1;
                  end else begin
                     lvl_d = lvl_q + 1'b1;
                  end
               end
            end else if (state_q == StChoose) begin
               for (int unsigned i = 0; i < NUM_PLAYERS; i++) begin
                  if (turn_q[i] && key_valid) begin
                     lk = key_lookup(i, key_code);
                     if (lk[2]) begin
                        hit  = 1'b1;
                        pick = lk[1:0];
                     end
                  end
               end
               if (hit || cnt_q == CntLast) begin
                  for (int unsigned i = 0; i < NUM_PLAYERS; i++) begin
                     if (turn_q[i]) begin
                        choice_d[2*i +: 2] = pick;
                        cv_d[i]            = 1'b1;
                     end
                  end
                  go_d    = 1'b1;
                  state_d = StAttack;
                  cnt_d   = '0;
               end else begin
                  cnt_d = cnt_q + 1'b1;
               end
            end else if (collision_detected) begin
               turn_d  = {turn_q[NUM_PLAYERS-2:0], turn_q[NUM_PLAYERS-1]};
               cv_d    = cv_q & ~turn_d;
               state_d = StChoose;
               cnt_d   = '0;
            end
         end
         StDone: state_d = StIdle;
         default: state_d = StIdle;
      endcase
      boss_d = (32'(win_d) >= BOSS_WINS);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= StIdle;
         turn_q   <= '0;
         choice_q <= '0;
         cv_q     <= '0;
         go_q     <= 1'b0;
         cnt_q    <= '0;
         win_q    <= '0;
         lvl_q    <= '0;
         lu_q     <= 1'b0;
         boss_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         turn_q   <= turn_d;
         choice_q <= choice_d;
         cv_q     <= cv_d;
         go_q     <= go_d;
         cnt_q    <= cnt_d;
         win_q    <= win_d;
         lvl_q    <= lvl_d;
         lu_q     <= lu_d;
         boss_q   <= boss_d;
      end
   end

   assign turn         = turn_q;
   assign choice       = choice_q;
   assign choice_valid = cv_q;
   assign attack_go    = go_q;
   assign win_count    = win_q;
   assign level_up     = lu_q;
   assign boss         = boss_q;

endmodule

// File: doc/battle_turn_ctrl.md
BATTLE_TURN_CTRL -- requirements
Module: battle_turn_ctrl

Interface
REQ-001 The block SHALL have parameter NUM_PLAYERS, default 2, meaning the number of combatants (legal 2..4).
REQ-002 The block SHALL have parameter WIN_W, default 8, meaning the win counter width.
REQ-003 The block SHALL have parameter LEVEL_WINS, default 4, meaning the wins per level_up pulse (legal 1..2^WIN_W-1).
REQ-004 The block SHALL have parameter BOSS_WINS, default 12, meaning the win count at or above which boss asserts.
REQ-005 The block SHALL have parameter TIMEOUT_CYC, default 50_000_000, meaning the CHOOSE-state cycles before the default choice applies (legal >= 2).
REQ-006 The block SHALL have port clk, input, 1 bit: system clock, all logic on rising edge.
REQ-007 The block SHALL have port rst, input, 1 bit: reset, asynchronous, active-high.
REQ-008 The block SHALL have port key_valid, input, 1 bit: one-cycle strobe qualifying key_code.
REQ-009 The block SHALL have port key_code, input, 8 bits: PS/2 make scan code.
REQ-010 The block SHALL have port battle_start, input, 1 bit: start-battle strobe.
REQ-011 The block SHALL have port collision_detected, input, 1 bit: attack-landed strobe from the game engine.
REQ-012 The block SHALL have ports player_win and enemy_win, inputs, 1 bit each: battle-outcome strobes.
REQ-013 The block SHALL have port turn, output, NUM_PLAYERS bits: one-hot active combatant, all-zero when not in battle.
REQ-014 The block SHALL have port choice, output, 2*NUM_PLAYERS bits: per-player attack code, player i in bits [2i+1:2i] (00 punch, 01 kick, 10 bat, 11 sword).
REQ-015 The block SHALL have port choice_valid, output, NUM_PLAYERS bits: per-player choice latched this turn.
REQ-016 The block SHALL have port attack_go, output, 1 bit: one-cycle pulse when the active player's choice is committed.
REQ-017 The block SHALL have ports win_count (output, WIN_W bits), level_up (output, 1-bit pulse) and boss (output, 1-bit level).

Function
REQ-018 The FSM SHALL have states IDLE, CHOOSE, ATTACK and DONE.
REQ-019 Key maps (punch, kick, bat, sword) SHALL be: P0 1C,1B,23,1D; P1 3B,42,4B,43; P2 16,1E,26,25; P3 70,69,72,7A; maps of players >= NUM_PLAYERS SHALL be ignored.
REQ-020 In IDLE, battle_start SHALL move the FSM to CHOOSE next cycle, with turn set to player 0 and all choice_valid and choice cleared.
REQ-021 In CHOOSE, key_valid with a code in the active player's map SHALL latch choice, set that player's choice_valid, pulse attack_go for one cycle, and enter ATTACK; all other codes SHALL be ignored.
REQ-022 In CHOOSE, a cycle counter SHALL reset on entry; on the cycle it reaches TIMEOUT_CYC-1 without a valid key, the block SHALL commit choice 00 exactly as in REQ-021.
REQ-023 In ATTACK, collision_detected SHALL rotate turn to the next index (NUM_PLAYERS-1 wraps to 0), clear the new active player's choice_valid, and return to CHOOSE; keys SHALL be ignored in ATTACK.
REQ-024 collision_detected outside ATTACK SHALL be ignored.
REQ-025 player_win or enemy_win in CHOOSE or ATTACK SHALL enter DONE with turn cleared, overriding a same-cycle key or collision; these strobes SHALL be ignored in IDLE and DONE.
REQ-026 If player_win and enemy_win coincide, enemy_win SHALL take priority and win_count SHALL NOT change.
REQ-027 On an accepted player_win, win_count SHALL increment by 1, saturating at 2^WIN_W-1.
REQ-028 level_up SHALL pulse one cycle, concurrent with DONE entry, whenever the new win_count is a nonzero multiple of LEVEL_WINS; there SHALL be no pulse once saturated.
REQ-029 boss SHALL equal (win_count >= BOSS_WINS), registered.
REQ-030 DONE SHALL return to IDLE after exactly one cycle; a battle_start received while in DONE SHALL be ignored.
REQ-031 A battle_start in CHOOSE or ATTACK SHALL be ignored.

Reset
REQ-032 On rst=1, asynchronously: state IDLE, turn 0, choice 0, choice_valid 0, attack_go 0, win_count 0, level_up 0, boss 0, timeout counter 0.
REQ-033 Reset asserted mid-battle SHALL abort the battle; win_count is not preserved across reset.

Verification
REQ-034 battle_start; key 1C -> attack_go pulse, choice[1:0]=00, choice_valid=01, state ATTACK; collision -> turn=10; key 43 -> choice[3:2]=11.
REQ-035 NUM_PLAYERS=3: three collisions -> turn sequence 001,010,100,001; key 3B while turn=001 -> ignored, no attack_go.
REQ-036 TIMEOUT_CYC=10, no key -> attack_go exactly 10 cycles after CHOOSE entry, choice=00.
REQ-037 LEVEL_WINS=4, BOSS_WINS=12: 12 won battles -> level_up on wins 4, 8, 12; boss=1 from win 12; WIN_W=4, 20 wins -> win_count holds at 15.
REQ-038 Same-cycle player_win and enemy_win -> DONE, win_count unchanged, no level_up pulse.
REQ-039 rst pulse during ATTACK -> all outputs 0 immediately; next battle_start restarts at turn=player 0.
